// File: rtl/pixel_coord_gen.sv
// Raster coordinate generator: walks a rectangular pixel region with a
// programmable X stride and emits one (x, y) beat per valid/ready handshake.
module pixel_coord_gen #(
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [XW-1:0] step,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_end,
    output logic          frame_end,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Resolution limits widened by one bit so H_RES/V_RES themselves fit.
    localparam logic [XW:0] LP_H_RES = (XW+1)'(H_RES);
    localparam logic [YW:0] LP_V_RES = (YW+1)'(V_RES);

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y0;
    logic [YW-1:0] r_y1;
    logic [XW-1:0] r_step;
    logic          r_mode;
    logic          r_err;

    logic [XW:0]   w_nx;
    logic          w_row_last;
    logic          w_frame_last;
    logic          w_reject;

    // Next x is one bit wider so a stride past the top of the range cannot wrap.
    assign w_nx         = {1'b0, r_x} + {1'b0, r_step};
    assign w_row_last   = (w_nx > {1'b0, r_x1});
    assign w_frame_last = w_row_last && (r_y == r_y1);

    assign w_reject = (x0 > x1) || (y0 > y1) ||
                      ({1'b0, x1} >= LP_H_RES) || ({1'b0, y1} >= LP_V_RES) ||
                      (step == '0);

    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign x         = r_x;
    assign y         = r_y;
    assign line_end  = out_valid && w_row_last;
    assign frame_end = out_valid && w_frame_last;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_step  <= '0;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_x0    <= x0;
                            r_x1    <= x1;
                            r_y0    <= y0;
                            r_y1    <= y1;
                            r_step  <= step;
                            r_mode  <= mode;
                            r_x     <= x0;
                            r_y     <= y0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // abort wins over any advance; a beat accepted this cycle is simply dropped.
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (out_ready) begin
                        if (!w_row_last) begin
                            r_x <= w_nx[XW-1:0];
                        end else if (!w_frame_last) begin
                            r_x <= r_x0;
                            r_y <= r_y + YW'(1);
                        end else if (r_mode) begin
                            r_x <= r_x0;
                            r_y <= r_y0;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen: table-driven beat/start vectors plus
// hand-written sequences for backpressure, continuous mode, abort and reset.
module tb_pixel_coord_gen;

    localparam int XW = 9;
    localparam int YW = 8;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          mode;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [XW-1:0] step;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_end;
    logic          frame_end;
    logic          busy;
    logic          done;
    logic          err;

    pixel_coord_gen #(.XW(XW), .YW(YW), .H_RES(320), .V_RES(240)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .mode      (mode),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .step      (step),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .line_end  (line_end),
        .frame_end (frame_end),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [XW-1:0] bx;
        logic [YW-1:0] by;
        logic          le;
        logic          fe;
    } beat_t;

    typedef struct {
        logic [XW-1:0] sx0;
        logic [XW-1:0] sx1;
        logic [XW-1:0] sstep;
        logic [YW-1:0] sy0;
        logic [YW-1:0] sy1;
        logic          exp_err;
    } start_vec_t;

    int         n_vec  = 0;
    int         n_miss = 0;
    beat_t      beats[$];
    beat_t      stride_tbl[6];
    beat_t      cont_tbl[4];
    start_vec_t svec[7];
    bit         saw_done;
    bit         saw_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a walk, then collect accepted beats until max_beats are consumed.
    // Returns at the negedge where the last beat's handshake is being presented.
    task automatic walk(input logic [XW-1:0] ax0, input logic [XW-1:0] ax1,
                        input logic [XW-1:0] astep, input logic [YW-1:0] ay0,
                        input logic [YW-1:0] ay1, input logic amode,
                        input int max_beats, input bit bp, input bit start_in_run);
        bit [5:0] pat = 6'b101001;
        int       pi  = 0;
        int       cyc = 0;
        bit       held = 1'b0;
        logic     rdy;
        beat_t    hb;
        beat_t    cur;
        beats.delete();
        saw_done = 1'b0;
        saw_idle = 1'b0;
        @(negedge Clk);
        x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; step = astep; mode = amode;
        start = 1'b1;
        @(negedge Clk);
        if (start_in_run) begin
            x0 = 0; x1 = 100; y0 = 0; y1 = 100; step = 1; mode = ~amode;
        end else begin
            start = 1'b0;
        end
        while (beats.size() < max_beats && cyc < 80000) begin
            if (done) saw_done = 1'b1;
            if (!busy) saw_idle = 1'b1;
            if (held) begin
                check("hold_x", x, hb.bx);
                check("hold_y", y, hb.by);
                check("hold_line_end", line_end, hb.le);
                check("hold_frame_end", frame_end, hb.fe);
                held = 1'b0;
            end
            rdy = bp ? pat[pi % 6] : 1'b1;
            pi++;
            out_ready = rdy;
            if (out_valid) begin
                cur = '{x, y, line_end, frame_end};
                if (rdy) beats.push_back(cur);
                else begin
                    held = 1'b1;
                    hb   = cur;
                end
            end
            cyc++;
            if (beats.size() < max_beats) @(negedge Clk);
        end
        start = 1'b0;
        check("beat_count", beats.size(), max_beats);
    endtask

    task automatic check_tbl(input string name, input beat_t exp[6]);
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            check({name, "_x"}, beats[i].bx, exp[i].bx);
            check({name, "_y"}, beats[i].by, exp[i].by);
            check({name, "_le"}, beats[i].le, exp[i].le);
            check({name, "_fe"}, beats[i].fe, exp[i].fe);
        end
    endtask

    // After the last one-shot beat: one DONE cycle, then IDLE.
    task automatic post_oneshot(input string name);
        @(negedge Clk);
        check({name, "_done_pulse"}, done, 1'b1);
        check({name, "_done_busy"}, busy, 1'b1);
        check({name, "_done_valid"}, out_valid, 1'b0);
        @(negedge Clk);
        check({name, "_idle_done"}, done, 1'b0);
        check({name, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int ex;
        int ey;
        int errs;

        stride_tbl[0] = '{9'd2,  8'd5, 1'b0, 1'b0};
        stride_tbl[1] = '{9'd6,  8'd5, 1'b0, 1'b0};
        stride_tbl[2] = '{9'd10, 8'd5, 1'b1, 1'b0};
        stride_tbl[3] = '{9'd2,  8'd6, 1'b0, 1'b0};
        stride_tbl[4] = '{9'd6,  8'd6, 1'b0, 1'b0};
        stride_tbl[5] = '{9'd10, 8'd6, 1'b1, 1'b1};

        cont_tbl[0] = '{9'd7, 8'd3, 1'b0, 1'b0};
        cont_tbl[1] = '{9'd8, 8'd3, 1'b1, 1'b0};
        cont_tbl[2] = '{9'd7, 8'd4, 1'b0, 1'b0};
        cont_tbl[3] = '{9'd8, 8'd4, 1'b1, 1'b1};

        //            x0     x1      step   y0     y1     err
        svec[0] = '{9'd0,  9'd320, 9'd1, 8'd0,  8'd10,  1'b1};
        svec[1] = '{9'd0,  9'd10,  9'd0, 8'd0,  8'd10,  1'b1};
        svec[2] = '{9'd0,  9'd10,  9'd1, 8'd10, 8'd9,   1'b1};
        svec[3] = '{9'd5,  9'd4,   9'd1, 8'd0,  8'd0,   1'b1};
        svec[4] = '{9'd0,  9'd10,  9'd1, 8'd0,  8'd240, 1'b1};
        svec[5] = '{9'd3,  9'd9,   9'd2, 8'd1,  8'd1,   1'b0};
        svec[6] = '{9'd0,  9'd319, 9'd1, 8'd0,  8'd239, 1'b0};

        Reset_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; step = '0;

        repeat (2) @(negedge Clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        Reset_n = 1'b1;

        // Full frame, one-shot, always ready.
        walk(0, 319, 1, 0, 239, 1'b0, 76800, 1'b0, 1'b0);
        ex = 0; ey = 0; errs = 0;
        foreach (beats[i]) begin
            if (int'(beats[i].bx) != ex || int'(beats[i].by) != ey ||
                beats[i].le != (ex + 1 > 319) || beats[i].fe != (ex + 1 > 319 && ey == 239))
                errs++;
            if (ex == 319) begin ex = 0; ey++; end
            else ex++;
        end
        check("frame_model_errs", errs, 0);
        if (beats.size() == 76800) begin
            check("frame_first_x", beats[0].bx, 0);
            check("frame_first_y", beats[0].by, 0);
            check("frame_b320_x", beats[319].bx, 319);
            check("frame_b320_y", beats[319].by, 0);
            check("frame_b320_le", beats[319].le, 1'b1);
            check("frame_last_x", beats[76799].bx, 319);
            check("frame_last_y", beats[76799].by, 239);
            check("frame_last_le", beats[76799].le, 1'b1);
            check("frame_last_fe", beats[76799].fe, 1'b1);
        end
        post_oneshot("frame");

        // Stride 4, no backpressure.
        walk(2, 13, 4, 5, 6, 1'b0, 6, 1'b0, 1'b0);
        check_tbl("stride", stride_tbl);
        post_oneshot("stride");

        // Same region with ready pattern 1,0,0,1,0,1.
        walk(2, 13, 4, 5, 6, 1'b0, 6, 1'b1, 1'b0);
        check_tbl("bp", stride_tbl);
        post_oneshot("bp");

        // start held high with different bounds while running is ignored.
        walk(2, 13, 4, 5, 6, 1'b0, 6, 1'b0, 1'b1);
        check_tbl("start_in_run", stride_tbl);
        post_oneshot("start_in_run");

        // Single-pixel region at the far corner.
        walk(319, 319, 1, 239, 239, 1'b0, 1, 1'b0, 1'b0);
        if (beats.size() == 1) begin
            check("single_x", beats[0].bx, 319);
            check("single_y", beats[0].by, 239);
            check("single_le", beats[0].le, 1'b1);
            check("single_fe", beats[0].fe, 1'b1);
        end
        post_oneshot("single");

        // Continuous wrap-around, then abort.
        walk(7, 8, 1, 3, 4, 1'b1, 10, 1'b0, 1'b0);
        foreach (beats[i]) begin
            check("cont_x", beats[i].bx, cont_tbl[i % 4].bx);
            check("cont_y", beats[i].by, cont_tbl[i % 4].by);
            check("cont_le", beats[i].le, cont_tbl[i % 4].le);
            check("cont_fe", beats[i].fe, cont_tbl[i % 4].fe);
        end
        check("cont_no_done", saw_done, 1'b0);
        check("cont_busy_held", saw_idle, 1'b0);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge Clk);
        check("abort_done_after", done, 1'b0);

        // Start acceptance / rejection table.
        for (int i = 0; i < 7; i++) begin
            x0 = svec[i].sx0; x1 = svec[i].sx1; step = svec[i].sstep;
            y0 = svec[i].sy0; y1 = svec[i].sy1; mode = 1'b0;
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
            check("start_err", err, svec[i].exp_err);
            check("start_busy", busy, !svec[i].exp_err);
            check("start_valid", out_valid, !svec[i].exp_err);
            if (!svec[i].exp_err) begin
                check("start_x", x, svec[i].sx0);
                check("start_y", y, svec[i].sy0);
                abort = 1'b1;
            end
            @(negedge Clk);
            abort = 1'b0;
            check("start_err_clear", err, 1'b0);
            check("start_back_idle", busy, 1'b0);
        end

        // Asynchronous reset between clock edges mid-walk.
        x0 = 0; x1 = 319; y0 = 0; y1 = 239; step = 1; mode = 1'b0; out_ready = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        check("pre_reset_valid", out_valid, 1'b1);
        check("pre_reset_x", x, 5);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_x", x, 0);
        check("async_rst_y", y, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("post_rst_valid", out_valid, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pixel_coord_gen.md
Name: pixel_coord_gen

Overview:
Sequential raster-coordinate generator for the GPU datapath. It walks a rectangular pixel region (x0..x1, y0..y1) with a programmable X stride and emits one (x, y) coordinate per valid/ready handshake. It flags line and frame boundaries and supports one-shot or continuous (wrap-around) operation. It replaces the hard-wired 320/240 increment-with-carry behaviour in the ALU with a parametrised, back-pressurable stream source for the fill and blit engines.

Parameters:
XW, 9, width of x coordinate and stride
YW, 8, width of y coordinate
H_RES, 320, horizontal resolution; legal x range 0..H_RES-1
V_RES, 240, vertical resolution; legal y range 0..V_RES-1

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
start  in  1  request a new walk; sampled only in IDLE
mode  in  1  0 = one-shot, 1 = continuous; sampled with start
x0  in  XW  region left bound, inclusive
x1  in  XW  region right bound, inclusive
y0  in  YW  region top bound, inclusive
y1  in  YW  region bottom bound, inclusive
step  in  XW  x stride, must be nonzero
abort  in  1  terminate the walk immediately
out_valid  out  1  coordinate beat valid
out_ready  in  1  consumer accepts beat
x  out  XW  current x
y  out  YW  current y
line_end  out  1  current beat is last of its row
frame_end  out  1  current beat is last of the region
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at end of a one-shot walk
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset: state=IDLE. x, y, out_valid, busy, done and err are all 0. The latched bounds, stride and mode are all cleared to 0.
- States:
  - IDLE: out_valid=0, busy=0.
  - RUN: out_valid=1.
  - DONE: lasts one cycle with done=1 and busy=1, then goes to IDLE.
- IDLE, start=1:
  - Rejected if any of the following holds: x0>x1, y0>y1, x1>=H_RES, y1>=V_RES, or step==0. On rejection, err=1 for the next cycle only and the state stays IDLE.
  - Otherwise, latch x0/x1/y0/y1/step/mode, load x=x0 and y=y0, and enter RUN. out_valid rises on the cycle after start, so latency is 1.
- start is ignored in RUN and DONE. Bound, stride and mode inputs are don't-care outside the start cycle.
- RUN, out_valid=1 and out_ready=0: x, y, line_end and frame_end hold stable. No advance.
- RUN, handshake (out_valid and out_ready):
  - Compute nx = x + step in XW+1 bits, so there is no silent wrap.
  - nx <= x1: x = nx.
  - nx > x1 (line_end=1) and y != y1: x = x0, y = y+1.
  - nx > x1 and y == y1 (frame_end=1):
    - mode=0: go to DONE; out_valid=0 next cycle.
    - mode=1: x = x0, y = y0, stay in RUN. No done pulse.
- line_end and frame_end are combinational from the current x, y and latched bounds. They are qualified only by out_valid.
- abort=1 in RUN or DONE: go to IDLE next cycle. out_valid=0, no done pulse, and a pending handshake in that cycle is still counted as consumed. abort in IDLE has no effect. abort takes priority over the advance and DONE transitions.
- Boundary cases:
  - A single-pixel region (x0=x1, y0=y1) yields one beat with line_end=frame_end=1.
  - If step > x1-x0, every beat is line_end.
- Async reset mid-RUN: outputs drop to reset values immediately, without waiting for a Clk edge.

Test Plan:
1. Full-frame one-shot: region (0,0)-(319,239), step=1, mode=0, out_ready=1.
   - Required: 76800 beats. First beat (0,0). Beat 320 is (319,0) with line_end. Last beat (319,239) with line_end=frame_end=1. done=1 on the following cycle, then busy=0.
2. Stride: region (2,5)-(13,6), step=4.
   - Required beats: (2,5), (6,5), (10,5)+line_end, (2,6), (6,6), (10,6)+line_end+frame_end. Then done.
3. Backpressure: scenario 2 with out_ready pattern 1,0,0,1,0,1,...
   - Required: x, y and flags are unchanged across every ready=0 cycle. The same 6-beat sequence is produced with no beat lost or duplicated.
4. Continuous: region (7,3)-(8,4), step=1, mode=1, ready=1, run 10 beats.
   - Required: (7,3), (8,3), (7,4), (8,4)+frame_end, then (7,3) repeating. busy stays 1 and done never asserts. abort then gives out_valid=0 and busy=0 on the next cycle, with no done.
5. Rejects:
   - start with x1=320: err pulses for 1 cycle, busy=0, out_valid=0.
   - Same for step=0 and for y0=10, y1=9.
   - start while RUN is ignored: the sequence is unaffected.
6. Reset: drop Reset_n mid-walk, between clock edges.
   - Required: out_valid, busy and x/y go to 0 asynchronously. After release, IDLE is held until the next start.
